// File: rtl/iob_axil_arb.sv
// Arbitrates N_MGR IOb requesters onto one IOb-to-AXI-Lite bridge, one transaction at a time.
// Define IOB_AXIL_ARB_RR_EN for round-robin arbitration; the default is fixed priority (lowest index wins).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner; any pending request is arbitrated on this edge
// ST_REQ   | granted request presented downstream, waiting for m_ready_i
// ST_RDATA | read accepted, waiting for m_rvalid_i & granted s_rready_i
module iob_axil_arb #(
    parameter int N_MGR  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,
    input  logic [N_MGR-1:0]           s_valid_i,
    input  logic [N_MGR*ADDR_W-1:0]    s_addr_i,
    input  logic [N_MGR*DATA_W-1:0]    s_wdata_i,
    input  logic [N_MGR*DATA_W/8-1:0]  s_wstrb_i,
    output logic [N_MGR-1:0]           s_ready_o,
    output logic [N_MGR-1:0]           s_rvalid_o,
    output logic [DATA_W-1:0]          s_rdata_o,
    input  logic [N_MGR-1:0]           s_rready_i,
    output logic                       m_valid_o,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic [DATA_W/8-1:0]        m_wstrb_o,
    input  logic                       m_ready_i,
    input  logic                       m_rvalid_i,
    input  logic [DATA_W-1:0]          m_rdata_i,
    output logic                       m_rready_o,
    output logic [N_MGR-1:0]           grant_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(N_MGR);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    localparam logic [N_MGR-1:0] GRANT_ONE = N_MGR'(1);

    logic [1:0]        state;
    logic [N_MGR-1:0]  grant;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  win_idx;

    logic              g_valid;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;
    logic              g_write;
    logic              g_rready;
    logic              in_req;
    logic              in_rdata;

    assign g_valid  = s_valid_i[idx];
    assign g_addr   = s_addr_i[int'(idx)*ADDR_W +: ADDR_W];
    assign g_wdata  = s_wdata_i[int'(idx)*DATA_W +: DATA_W];
    assign g_wstrb  = s_wstrb_i[int'(idx)*STRB_W +: STRB_W];
    assign g_write  = |g_wstrb;
    assign g_rready = s_rready_i[idx];

`ifdef IOB_AXIL_ARB_RR_EN
    logic [IDX_W-1:0] ptr;
    logic             done;
    int               rr_j;

    // Scan downward from the farthest offset so the requester at ptr wins last-written.
    always_comb begin
        win_idx = '0;
        rr_j    = 0;
        for (int off = N_MGR - 1; off >= 0; off--) begin
            rr_j = int'(ptr) + off;
            if (rr_j >= N_MGR) rr_j = rr_j - N_MGR;
            if (s_valid_i[rr_j]) win_idx = IDX_W'(rr_j);
        end
    end

    // Aborted requests do not advance the pointer; only real completions do.
    assign done = (state == ST_REQ && g_valid && m_ready_i && g_write) ||
                  (state == ST_RDATA && m_rvalid_i && g_rready);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr <= '0;
        end else if (cke_i && done) begin
            ptr <= (idx == IDX_W'(N_MGR - 1)) ? '0 : idx + 1'b1;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = N_MGR - 1; i >= 0; i--) begin
            if (s_valid_i[i]) win_idx = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= ST_IDLE;
            grant <= '0;
            idx   <= '0;
        end else if (cke_i) begin
            case (state)
                ST_IDLE: begin
                    if (|s_valid_i) begin
                        state <= ST_REQ;
                        idx   <= win_idx;
                        grant <= GRANT_ONE << win_idx;
                    end
                end
                ST_REQ: begin
                    if (!g_valid) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end else if (m_ready_i) begin
                        if (g_write) begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end else begin
                            state <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (m_rvalid_i && g_rready) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign in_req   = (state == ST_REQ);
    assign in_rdata = (state == ST_RDATA);

    assign m_valid_o  = in_req & g_valid;
    assign m_addr_o   = in_req ? g_addr  : '0;
    assign m_wdata_o  = in_req ? g_wdata : '0;
    assign m_wstrb_o  = in_req ? g_wstrb : '0;
    assign m_rready_o = in_rdata & g_rready;

    // grant is one-hot of idx, so it doubles as the per-requester routing mask.
    assign s_ready_o  = (in_req & g_valid & m_ready_i) ? grant : '0;
    assign s_rvalid_o = (in_rdata & m_rvalid_i) ? grant : '0;
    assign s_rdata_o  = m_rdata_i;
    assign grant_o    = grant;

endmodule

// File: tb/tb_iob_axil_arb.sv
// Self-checking bench for iob_axil_arb; contention expectations follow IOB_AXIL_ARB_RR_EN.
module tb_iob_axil_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk_i = 1'b0;
    logic              arst_n_i = 1'b1;
    logic              cke_i = 1'b1;
    logic [N-1:0]      s_valid_i = '0;
    logic [N*AW-1:0]   s_addr_i = '0;
    logic [N*DW-1:0]   s_wdata_i = '0;
    logic [N*SW-1:0]   s_wstrb_i = '0;
    logic [N-1:0]      s_ready_o;
    logic [N-1:0]      s_rvalid_o;
    logic [DW-1:0]     s_rdata_o;
    logic [N-1:0]      s_rready_i = '0;
    logic              m_valid_o;
    logic [AW-1:0]     m_addr_o;
    logic [DW-1:0]     m_wdata_o;
    logic [SW-1:0]     m_wstrb_o;
    logic              m_ready_i = 1'b0;
    logic              m_rvalid_i = 1'b0;
    logic [DW-1:0]     m_rdata_i = '0;
    logic              m_rready_o;
    logic [N-1:0]      grant_o;

    always #5 clk_i = ~clk_i;

    iob_axil_arb #(.N_MGR(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .s_valid_i(s_valid_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
        .s_wstrb_i(s_wstrb_i), .s_ready_o(s_ready_o), .s_rvalid_o(s_rvalid_o),
        .s_rdata_o(s_rdata_o), .s_rready_i(s_rready_i),
        .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_ready_i(m_ready_i), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_rready_o(m_rready_o), .grant_o(grant_o)
    );

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } txn_t;

    txn_t          exp_q[$];
    logic [DW-1:0] rd_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] st);
        s_valid_i[k] = 1'b1;
        s_addr_i[k*AW +: AW] = a;
        s_wdata_i[k*DW +: DW] = d;
        s_wstrb_i[k*SW +: SW] = st;
    endtask

    task automatic drop_req(input int k);
        s_valid_i[k] = 1'b0;
        s_wstrb_i[k*SW +: SW] = '0;
    endtask

    task automatic clear_inputs();
        s_valid_i = '0; s_addr_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
        s_rready_i = '0; m_ready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        cke_i = 1'b1;
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        clear_inputs();
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;
    endtask

    // Returns at the negedge where m_valid_o is first seen, or after the cycle budget.
    task automatic wait_mvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (m_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        txn_t z;
        #1 arst_n_i = 1'b0;
        s_valid_i = '1; s_wstrb_i = '1; s_rready_i = '1;
        m_ready_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'hA5A5_0F0F;
        repeat (2) @(negedge clk_i);
        z = '0;
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL rst_grant: got %b exp 0000", grant_o); else n_pass++;
        n_checks++; if (m_valid_o !== 1'b0) $display("FAIL rst_m_valid: got %b exp 0", m_valid_o); else n_pass++;
        n_checks++; if (s_ready_o !== 4'b0000) $display("FAIL rst_s_ready: got %b exp 0000", s_ready_o); else n_pass++;
        n_checks++; if (s_rvalid_o !== 4'b0000) $display("FAIL rst_s_rvalid: got %b exp 0000", s_rvalid_o); else n_pass++;
        n_checks++; if (m_rready_o !== 1'b0) $display("FAIL rst_m_rready: got %b exp 0", m_rready_o); else n_pass++;
        n_checks++; if ({grant_o, m_addr_o, m_wdata_o, m_wstrb_o} !== z)
            $display("FAIL rst_m_bus: got %h %h %h exp zeros", m_addr_o, m_wdata_o, m_wstrb_o); else n_pass++;
        n_checks++; if (s_rdata_o !== 32'hA5A5_0F0F) $display("FAIL rst_rdata_pass: got %h exp a5a50f0f", s_rdata_o); else n_pass++;
        clear_inputs();
        @(posedge clk_i); #1 arst_n_i = 1'b1;
        // First arbitration must wait for an enabled edge.
        @(posedge clk_i); #1 cke_i = 1'b0;
        set_req(1, 32'h30, 32'h0, 4'h0);
        repeat (2) @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL cke_hold: got %b exp 0000", grant_o); else n_pass++;
        @(posedge clk_i); #1 cke_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL cke_no_early: got %b exp 0000", grant_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0010) $display("FAIL cke_first_arb: got %b exp 0010", grant_o); else n_pass++;
        @(posedge clk_i); #1 drop_req(1);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_contention();
        txn_t e;
        int   last;
        bit   seen3;
        do_reset();
        @(posedge clk_i); #1;
`ifdef IOB_AXIL_ARB_RR_EN
        for (int k = 0; k < N; k++) set_req(k, 32'h100 + k, 32'h1000 + k, 4'hF);
        for (int k = 0; k < 5; k++) exp_q.push_back({4'(1 << (k % N)), 32'h100 + (k % N), 32'h1000 + (k % N), 4'hF});
`else
        set_req(0, 32'h100, 32'h1000, 4'hF);
        set_req(3, 32'h103, 32'h1003, 4'hF);
        for (int k = 0; k < 5; k++) exp_q.push_back({4'b0001, 32'h100, 32'h1000, 4'hF});
`endif
        m_ready_i = 1'b1;
        last = -1;
        seen3 = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk_i);
            if (grant_o[3]) seen3 = 1'b1;
            if (m_valid_o && m_ready_i) begin
                e = exp_q.pop_front();
                n_checks++; if ({grant_o, m_addr_o, m_wdata_o, m_wstrb_o} !== e)
                    $display("FAIL cont_txn: got %b %h %h exp %b %h %h", grant_o, m_addr_o, m_wdata_o, e.grant, e.addr, e.wdata);
                else n_pass++;
                if (last >= 0) begin
                    n_checks++; if (c - last !== 2) $display("FAIL cont_gap: got %0d cycles exp 2", c - last); else n_pass++;
                end
                last = c;
            end
        end
        n_checks++; if (exp_q.size() !== 0) $display("FAIL cont_timeout: got %0d pending exp 0", exp_q.size()); else n_pass++;
`ifndef IOB_AXIL_ARB_RR_EN
        n_checks++; if (seen3 !== 1'b0) $display("FAIL fixed_starve: got req3 granted exp never"); else n_pass++;
`endif
        exp_q.delete();
        @(posedge clk_i); #1 clear_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_write();
        txn_t e;
        @(posedge clk_i); #1;
        set_req(2, 32'h10, 32'hDEAD_BEEF, 4'hF);
        exp_q.push_back({4'b0100, 32'h10, 32'hDEAD_BEEF, 4'hF});
        @(negedge clk_i);
        n_checks++; if (m_valid_o !== 1'b0 || m_addr_o !== 32'h0)
            $display("FAIL wr_idle_out: got valid %b addr %h exp 0 0", m_valid_o, m_addr_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (m_valid_o !== 1'b1 || grant_o !== 4'b0100)
            $display("FAIL wr_latency: got valid %b grant %b exp 1 0100", m_valid_o, grant_o); else n_pass++;
        repeat (2) begin
            @(negedge clk_i);
            n_checks++; if (s_ready_o !== 4'b0000) $display("FAIL wr_early_ready: got %b exp 0000", s_ready_o); else n_pass++;
        end
        @(posedge clk_i); #1 m_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (s_ready_o !== 4'b0100) $display("FAIL wr_s_ready: got %b exp 0100", s_ready_o); else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wr_sb: got empty scoreboard exp one entry");
        else begin
            e = exp_q.pop_front();
            if ({grant_o, m_addr_o, m_wdata_o, m_wstrb_o} !== e)
                $display("FAIL wr_txn: got %b %h %h %h exp %b %h %h %h", grant_o, m_addr_o, m_wdata_o, m_wstrb_o, e.grant, e.addr, e.wdata, e.wstrb);
            else n_pass++;
        end
        @(posedge clk_i); #1 m_ready_i = 1'b0; drop_req(2);
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000 || m_valid_o !== 1'b0 || s_ready_o !== 4'b0000)
            $display("FAIL wr_done_idle: got grant %b valid %b ready %b exp 0000 0 0000", grant_o, m_valid_o, s_ready_o); else n_pass++;
    endtask

    task automatic test_read();
        txn_t          e;
        logic [DW-1:0] ed;
        bit            ok;
        @(posedge clk_i); #1;
        set_req(1, 32'h20, 32'h0, 4'h0);
        exp_q.push_back({4'b0010, 32'h20, 32'h0, 4'h0});
        rd_q.push_back(32'h1234_5678);
        wait_mvalid(ok);
        n_checks++; if (!ok) $display("FAIL rd_wait_valid: got timeout exp m_valid_o"); else n_pass++;
        @(posedge clk_i); #1 m_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rd_sb: got empty scoreboard exp one entry");
        else begin
            e = exp_q.pop_front();
            if ({grant_o, m_addr_o, m_wdata_o, m_wstrb_o} !== e || s_ready_o !== 4'b0010)
                $display("FAIL rd_req: got %b %h %h ready %b exp %b %h %h ready 0010", grant_o, m_addr_o, m_wstrb_o, s_ready_o, e.grant, e.addr, e.wstrb);
            else n_pass++;
        end
        @(posedge clk_i); #1 m_ready_i = 1'b0; drop_req(1); s_rready_i[1] = 1'b1;
        @(negedge clk_i);
        n_checks++; if (m_rready_o !== 1'b1 || s_rvalid_o !== 4'b0000)
            $display("FAIL rd_rready: got rready %b rvalid %b exp 1 0000", m_rready_o, s_rvalid_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0010) $display("FAIL rd_grant_held: got %b exp 0010", grant_o); else n_pass++;
        @(posedge clk_i); #1 m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        n_checks++;
        if (rd_q.size() == 0) $display("FAIL rd_sb_data: got empty scoreboard exp one entry");
        else begin
            ed = rd_q.pop_front();
            if (s_rvalid_o !== 4'b0010 || s_rdata_o !== ed)
                $display("FAIL rd_data: got rvalid %b data %h exp 0010 %h", s_rvalid_o, s_rdata_o, ed);
            else n_pass++;
        end
        @(posedge clk_i); #1 m_rvalid_i = 1'b0; s_rready_i = '0;
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000 || m_rready_o !== 1'b0)
            $display("FAIL rd_done_idle: got grant %b rready %b exp 0000 0", grant_o, m_rready_o); else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        @(posedge clk_i); #1 set_req(1, 32'h40, 32'h0, 4'h0);
        wait_mvalid(ok);
        n_checks++; if (!ok || grant_o !== 4'b0010)
            $display("FAIL ab_grant: got ok %b grant %b exp 1 0010", ok, grant_o); else n_pass++;
        @(posedge clk_i); #1 drop_req(1);
        @(negedge clk_i);
        n_checks++; if (m_valid_o !== 1'b0 || s_ready_o !== 4'b0000)
            $display("FAIL ab_drop: got valid %b ready %b exp 0 0000", m_valid_o, s_ready_o); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000 || s_ready_o !== 4'b0000)
            $display("FAIL ab_idle: got grant %b ready %b exp 0000 0000", grant_o, s_ready_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        txn_t e;
        bit   ok;
        @(posedge clk_i); #1;
        set_req(2, 32'h50, 32'h0, 4'h0);
        s_rready_i[2] = 1'b1;
        wait_mvalid(ok);
        n_checks++; if (!ok) $display("FAIL rm_wait_valid: got timeout exp m_valid_o"); else n_pass++;
        @(posedge clk_i); #1 m_ready_i = 1'b1;
        @(posedge clk_i); #1 m_ready_i = 1'b0; drop_req(2);
        @(negedge clk_i);
        n_checks++; if (m_rready_o !== 1'b1 || grant_o !== 4'b0100)
            $display("FAIL rm_in_rdata: got rready %b grant %b exp 1 0100", m_rready_o, grant_o); else n_pass++;
        @(posedge clk_i); #2 arst_n_i = 1'b0;
        #1;
        n_checks++; if (grant_o !== 4'b0000 || m_rready_o !== 1'b0)
            $display("FAIL rm_async: got grant %b rready %b exp 0000 0", grant_o, m_rready_o); else n_pass++;
        #1 clear_inputs();
        @(posedge clk_i); #1 arst_n_i = 1'b1;
        set_req(0, 32'h60, 32'hCAFE_F00D, 4'hF);
        exp_q.push_back({4'b0001, 32'h60, 32'hCAFE_F00D, 4'hF});
        wait_mvalid(ok);
        n_checks++; if (!ok || grant_o !== 4'b0001)
            $display("FAIL rm_regrant: got ok %b grant %b exp 1 0001", ok, grant_o); else n_pass++;
        @(posedge clk_i); #1 m_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rm_sb: got empty scoreboard exp one entry");
        else begin
            e = exp_q.pop_front();
            if ({grant_o, m_addr_o, m_wdata_o, m_wstrb_o} !== e || s_ready_o !== 4'b0001)
                $display("FAIL rm_txn: got %b %h %h ready %b exp %b %h %h ready 0001", grant_o, m_addr_o, m_wdata_o, s_ready_o, e.grant, e.addr, e.wdata);
            else n_pass++;
        end
        @(posedge clk_i); #1 m_ready_i = 1'b0; drop_req(0);
        @(negedge clk_i);
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL rm_done_idle: got %b exp 0000", grant_o); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_write();
        test_read();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
